// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract unit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_slice_4.sv
// 4-bit ripple slice; also reports the carry into its top bit so the
// final slice can derive signed overflow.
module adder_slice_4
  import serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_carry,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_carry,
  output logic               o_carry_msb_in
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = i_carry;

  for (genvar g = 0; g < SLICE_W; g++) begin : g_bit
    full_adder u_fa (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_c (w_c[g]),
      .o_s (o_sum[g]),
      .o_c (w_c[g+1])
    );
  end

  assign o_carry        = w_c[SLICE_W];
  assign o_carry_msb_in = w_c[SLICE_W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slice.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract: one nibble per cycle, LSB first, with a final
// commit cycle so the visible result only changes when an operation completes.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, never together.
module nibble_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = clog2(NSLICE + 1);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] COMMIT     = CNT_W'(NSLICE);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cmsb;
  logic               r_carry_out;
  logic               r_overflow;
  logic               w_accept;
  logic               w_slice;
  logic               w_commit;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_carry;
  logic               w_slice_cmsb;

  adder_slice_4 u_slice (
    .i_a            (r_a[SLICE_W-1:0]),
    .i_b            (r_b[SLICE_W-1:0]),
    .i_carry        (r_carry),
    .o_sum          (w_slice_sum),
    .o_carry        (w_slice_carry),
    .o_carry_msb_in (w_slice_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (r_cnt == COMMIT) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_slice   = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: in_ready  = 1'b1;
      S_RUN: begin
        w_slice  = (r_cnt != COMMIT);
        w_commit = (r_cnt == COMMIT);
      end
      S_DONE: out_valid = 1'b1;
      default: ;
    endcase
    w_accept = in_ready & in_valid;
  end

  // Subtraction is folded in at accept time: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cmsb      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (w_slice) begin
      r_a     <= {SLICE_W'(0), r_a[WIDTH-1:SLICE_W]};
      r_b     <= {SLICE_W'(0), r_b[WIDTH-1:SLICE_W]};
      r_acc   <= {w_slice_sum, r_acc[WIDTH-1:SLICE_W]};
      r_carry <= w_slice_carry;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST_SLICE) r_cmsb <= w_slice_cmsb;
    end else if (w_commit) begin
      r_sum       <= r_acc;
      r_carry_out <= r_carry;
      r_overflow  <= r_carry ^ r_cmsb;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
